// File: rtl/fft_seq_pkg.sv
// Shared definitions for the FFT frame sequencer: bank geometry, FSM states
// and the word-offset helper used to pack 16-word buses.
package fft_seq_pkg;

  localparam int unsigned FFT_N = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_CAPTURE
  } fft_state_e;

  // Bit offset of word idx in a flat bus; word 0 sits in the LSBs.
  function automatic int unsigned word_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/sample_bank.sv
// One 16-word sample bank: a single write port and a flat read bus with
// word 0 in the LSBs.
module sample_bank
  import fft_seq_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [W-1:0]       data_i,
  output logic [FFT_N*W-1:0] rd_bus_o
);

  logic [W-1:0] mem_q [FFT_N];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FFT_N; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[idx_i] <= data_i;
    end
  end

  always_comb begin
    rd_bus_o = '0;
    for (int i = 0; i < FFT_N; i++) begin
      rd_bus_o[word_lsb(i, W) +: W] = mem_q[i];
    end
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Ping-pong sample collector and start/wait/capture controller in front of a
// 16-point FFT core, with timeout recovery and a frame counter.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | no transform running; start the oldest full bank when ready
// ST_START   | one-cycle new_t pulse, fft_t holds the bank under transform
// ST_WAIT    | waiting for done (first cycle ignored); down-counter timeout
// ST_CAPTURE | spectrum registered; free the bank, chain to a full one
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int unsigned W       = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               sample_valid_i,
  input  logic [W-1:0]       sample_data_i,
  output logic               sample_ready_o,
  output logic               fft_new_t_o,
  output logic [FFT_N*W-1:0] fft_t_o,
  input  logic               fft_done_i,
  input  logic [FFT_N*W-1:0] fft_f_i,
  output logic               spec_valid_o,
  output logic [FFT_N*W-1:0] spec_data_o,
  output logic [15:0]        frame_count_o,
  output logic               timeout_err_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(TIMEOUT - 1);

  fft_state_e         state_q, state_d;
  logic               wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [1:0]         full_q, full_d;
  logic               rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               spec_valid_q, spec_valid_d;
  logic [FFT_N*W-1:0] spec_data_q, spec_data_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic               timeout_err_q, timeout_err_d;

  logic               accept;
  logic               fill_done;
  logic [1:0]         full_now;
  logic               other_bank;
  logic [FFT_N*W-1:0] bus_a, bus_b;

  sample_bank #(.W(W)) u_bank_a (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (accept && !wr_bank_q),
    .idx_i    (wr_idx_q),
    .data_i   (sample_data_i),
    .rd_bus_o (bus_a)
  );

  sample_bank #(.W(W)) u_bank_b (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (accept && wr_bank_q),
    .idx_i    (wr_idx_q),
    .data_i   (sample_data_i),
    .rd_bus_o (bus_b)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      wr_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      full_q        <= '0;
      rd_bank_q     <= 1'b0;
      wait_cnt_q    <= '0;
      spec_valid_q  <= 1'b0;
      spec_data_q   <= '0;
      frame_count_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      wr_idx_q      <= wr_idx_d;
      full_q        <= full_d;
      rd_bank_q     <= rd_bank_d;
      wait_cnt_q    <= wait_cnt_d;
      spec_valid_q  <= spec_valid_d;
      spec_data_q   <= spec_data_d;
      frame_count_q <= frame_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    sample_ready_o = !rst_i && !full_q[wr_bank_q];
    accept         = sample_valid_i && sample_ready_o;
    fill_done      = accept && (wr_idx_q == IDX_W'(FFT_N - 1));
    // A bank completing this cycle counts as full so START follows immediately.
    full_now       = full_q | (fill_done ? (2'b01 << wr_bank_q) : 2'b00);
    other_bank     = !rd_bank_q;

    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    wr_idx_d      = wr_idx_q;
    full_d        = full_q;
    rd_bank_d     = rd_bank_q;
    wait_cnt_d    = wait_cnt_q;
    spec_valid_d  = 1'b0;
    spec_data_d   = spec_data_q;
    frame_count_d = frame_count_q;
    timeout_err_d = timeout_err_q;

    if (accept) begin
      wr_idx_d = wr_idx_q + IDX_W'(1);
    end
    if (fill_done) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
    end

    // Banks fill and free strictly alternately, so rd_bank always names the oldest.
    unique case (state_q)
      ST_IDLE: begin
        if (full_now[rd_bank_q]) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d    = ST_WAIT;
        wait_cnt_d = CNT_FIRST;
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - CNT_W'(1);
        if (fft_done_i && (wait_cnt_q != CNT_FIRST)) begin
          state_d       = ST_CAPTURE;
          spec_valid_d  = 1'b1;
          spec_data_d   = fft_f_i;
          frame_count_d = frame_count_q + 16'd1;
        end else if (wait_cnt_q == '0) begin
          state_d           = ST_IDLE;
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = other_bank;
          timeout_err_d     = 1'b1;
        end
      end
      ST_CAPTURE: begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = other_bank;
        state_d           = full_now[other_bank] ? ST_START : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign fft_new_t_o   = (state_q == ST_START);
  assign fft_t_o       = rd_bank_q ? bus_b : bus_a;
  assign spec_valid_o  = spec_valid_q;
  assign spec_data_o   = spec_data_q;
  assign frame_count_o = frame_count_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Front-end controller for the 16-point `FFT_Processor`. It collects streamed audio samples into ping-pong 16-sample banks and presents a full bank on the processor's `t0..t15` inputs. It pulses `new_t`, waits for `done`, then captures `f0..f15` into a registered spectrum frame for the display path. It also applies backpressure to the sample source, recovers from a hung FFT by timeout, and counts processed and failed frames.

## Interface
- `W`, 16: sample and bin width in bits; must equal the FFT port width.
- `TIMEOUT`, 64: cycles allowed from the `fft_new_t` pulse to `fft_done` before the frame is abandoned.
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sample_valid`  in  1  source has a sample on `sample_data`.
- `sample_data`  in  W  unsigned audio sample.
- `sample_ready`  out  1  sequencer accepts `sample_data` this cycle.
- `fft_new_t`  out  1  one-cycle start pulse to the FFT; drives `new_t`.
- `fft_t`  out  16*W  bank under transform; `t0` is in bits [W-1:0] and `t15` is in the MSBs.
- `fft_done`  in  1  FFT completion indication.
- `fft_f`  in  16*W  FFT outputs `f0..f15`, packed the same way as `fft_t`.
- `spec_valid`  out  1  one-cycle pulse when `spec_data` holds a new frame.
- `spec_data`  out  16*W  last captured spectrum, registered.
- `frame_count`  out  16  number of frames captured successfully; wraps at 2^16.
- `timeout_err`  out  1  sticky flag, set on any timeout; cleared only by `rst`.

## Operation
- Two sample banks, A and B, each 16×W. A fill pointer `wr_bank` and `wr_idx` (0..15) select the bank and slot being filled.
- A sample is accepted when `sample_valid && sample_ready`; `sample_data` is written to `bank[wr_bank][wr_idx]` and `wr_idx` increments.
- When slot 15 is accepted, the bank is marked full, `wr_bank` toggles and `wr_idx` returns to 0.
- `sample_ready` = 0 when the bank selected by `wr_bank` is still full, meaning it is under transform or waiting to be transformed; otherwise `sample_ready` = 1.
- FFT control FSM states:
  - IDLE: when any bank is full, load `rd_bank` with it, go to START.
  - START: `fft_new_t` = 1 for exactly this cycle, then go to WAIT.
  - WAIT: `fft_done` is ignored in the first cycle of WAIT (guard against stale `done`). From the second cycle on, the first `fft_done` = 1 goes to CAPTURE. If the WAIT cycle counter reaches TIMEOUT, go to IDLE, free `rd_bank` (its samples are discarded), and set `timeout_err`.
  - CAPTURE: load `fft_f` into `spec_data`, assert `spec_valid`, increment `frame_count`, free `rd_bank`, go to IDLE.
- `fft_t` always reflects `bank[rd_bank]` and must stay stable from START until the FSM leaves WAIT. The filling bank is never `rd_bank` while in START or WAIT.
- If both banks are full in IDLE, the older bank (the one filled first) is transformed first.
- Bank order is preserved: frames reach `spec_data` in the order they were filled.

## Timing
- Reset values: `sample_ready` 0; `fft_new_t` 0; `spec_valid` 0; `spec_data` 0; `fft_t` 0 (banks cleared); `frame_count` 0; `timeout_err` 0.
- After reset: `wr_bank` = A, `wr_idx` = 0, FSM in IDLE, and `sample_ready` = 1 from the first cycle after `rst` deasserts.
- Slot 15 accepted in cycle c, FSM in IDLE: START (`fft_new_t` = 1) in cycle c+1; WAIT begins at c+2; `fft_done` is sampled from c+3 onward.
- `fft_done` seen high in cycle d: `spec_valid` and the new `spec_data` appear in cycle d+1; the FSM is back in IDLE at d+2. If the other bank is already full, the next START is at d+2.
- With `fft_done` never asserted, `timeout_err` rises TIMEOUT cycles after the start of WAIT.
- When a bank is freed in cycle x and the source was stalled, `sample_ready` returns to 1 in cycle x+1.
- `rst` asserted mid-frame or mid-WAIT: all state returns to reset values on the next edge, partial banks are discarded, and no `spec_valid` is issued for the aborted frame.

## Structure
- Package `fft_seq_pkg`: `FFT_N` = 16, the FSM state enum (IDLE, START, WAIT, CAPTURE), and a helper function that packs/unpacks a 16-word bus.
- Sub-module `sample_bank`: one 16×W register bank with a write port (`we`, `idx`, `data`) and a flat 16*W read bus. Instantiate it twice.

## Test plan
- Single frame: feed 16 samples `10,0,10,0,…`; the FFT model asserts `done` 4 cycles after `new_t` → exactly one `fft_new_t` pulse; `fft_t` words are `10,0,…`; the model's `fft_f` appears on `spec_data` with `spec_valid` at done+1; `frame_count` = 1.
- Backpressure: continuous `sample_valid` while the model holds `done` low for 50 cycles → 32 samples accepted, then `sample_ready` = 0 until capture, then resumes; second frame processed in order.
- Stale done: `fft_done` held high before and during START → not accepted in the first WAIT cycle; capture happens on the first `done` from the second WAIT cycle onward, giving a one-cycle-late capture and no double `spec_valid`.
- Timeout with TIMEOUT = 64 and `done` never asserted → `timeout_err` = 1, no `spec_valid`, `frame_count` unchanged, bank freed. A following frame completes normally and `timeout_err` stays 1.
- Reset in WAIT: `rst` for one cycle → all outputs at reset values, no `spec_valid`; the next 16 samples produce a normal frame with `frame_count` = 1.
- Counter wrap: preload or run 65536 frames → `frame_count` wraps to 0.
